// File: rtl/icache_refill_if.sv
// icache_refill_if: cache-side refill request/fill port plus the 16-bit Wishbone imem master port.
interface icache_refill_if #(parameter int IDX_W = 3);
  logic             miss_i;
  logic [31:0]      miss_adr_i;
  logic             abort_i;
  logic             busy_o;
  logic             fill_we_o;
  logic [IDX_W-1:0] fill_idx_o;
  logic [15:0]      fill_dat_o;
  logic             crit_o;
  logic             done_o;
  logic             err_o;
  logic [31:0]      wb_adr_o;
  logic [1:0]       wb_sel_o;
  logic             wb_cyc_o;
  logic             wb_stb_o;
  logic [15:0]      wb_dat_i;
  logic             wb_ack_i;
  logic             wb_err_i;
  modport master (
    input  miss_i, miss_adr_i, abort_i, wb_dat_i, wb_ack_i, wb_err_i,
    output busy_o, fill_we_o, fill_idx_o, fill_dat_o, crit_o, done_o, err_o,
           wb_adr_o, wb_sel_o, wb_cyc_o, wb_stb_o
  );
  modport slave (
    output miss_i, miss_adr_i, abort_i, wb_dat_i, wb_ack_i, wb_err_i,
    input  busy_o, fill_we_o, fill_idx_o, fill_dat_o, crit_o, done_o, err_o,
           wb_adr_o, wb_sel_o, wb_cyc_o, wb_stb_o
  );
endinterface

// File: rtl/icache_refill.sv
// icache_refill: critical-word-first line fill over classic Wishbone single reads, one halfword per beat.
module icache_refill #(
  parameter int LINE_HW = 8,
  parameter int IDX_W   = 3
) (
  input logic              clk_i,
  input logic              rst_i,
  icache_refill_if.master  bus
);
  typedef enum logic {IDLE, BUS} state_t;
  localparam logic [IDX_W:0] LAST = (IDX_W+1)'(LINE_HW-1);
  state_t           r_state, w_next;
  logic [31:0]      r_base;
  logic [IDX_W-1:0] r_start;
  logic [IDX_W:0]   r_k;
  logic             r_abort, r_done, r_err;
  logic             w_bus, w_ack, w_err, w_last, w_start, w_done_nx;
  logic [IDX_W-1:0] w_idx;
  logic             w_unused;
  assign w_unused  = bus.miss_adr_i[0];
  assign w_bus     = r_state == BUS;
  assign w_err     = w_bus & bus.wb_err_i;
  assign w_ack     = w_bus & bus.wb_ack_i & ~bus.wb_err_i;
  assign w_last    = r_k == LAST;
  assign w_start   = (r_state == IDLE) & bus.miss_i & ~bus.abort_i;
  assign w_done_nx = w_ack & w_last & ~r_abort;
  assign w_idx     = r_start + r_k[IDX_W-1:0];
  always_comb begin
    w_next = r_state;
    if (w_start) w_next = BUS;
    if (w_err | (w_ack & (r_abort | w_last))) w_next = IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_base  <= '0;
      r_start <= '0;
      r_k     <= '0;
      r_abort <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_done_nx;
      r_err   <= w_err;
      // flag survives until the outstanding beat retires, then clears with the return to IDLE
      r_abort <= (w_next == IDLE) ? 1'b0 : (r_abort | (w_bus & bus.abort_i));
      if (w_start) begin
        r_base  <= {bus.miss_adr_i[31:IDX_W+1], {(IDX_W+1){1'b0}}};
        r_start <= bus.miss_adr_i[IDX_W:1];
        r_k     <= '0;
      end else if (w_ack) begin
        r_k <= r_k + 1'b1;
      end
    end
  end
  assign bus.busy_o     = w_bus;
  assign bus.wb_cyc_o   = w_bus;
  assign bus.wb_stb_o   = w_bus;
  assign bus.wb_sel_o   = 2'b11;
  assign bus.wb_adr_o   = r_base + 32'({w_idx, 1'b0});
  assign bus.fill_we_o  = w_ack & ~r_abort;
  assign bus.fill_idx_o = w_idx;
  assign bus.fill_dat_o = bus.wb_dat_i;
  assign bus.crit_o     = r_k == '0;
  assign bus.done_o     = r_done;
  assign bus.err_o      = r_err;
endmodule

// File: tb/tb_icache_refill.sv
// tb_icache_refill: table-driven fills against a beat-level model, plus abort/idle/reset sequences.
module tb_icache_refill;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_tot = 0;
  always #5 clk = ~clk;
  icache_refill_if #(.IDX_W(3)) bus ();
  icache_refill #(.LINE_HW(8), .IDX_W(3)) dut (.clk_i(clk), .rst_i(rst_n), .bus(bus.master));
  typedef struct {
    logic [31:0] adr;
    int          waits;
    int          abort_beat;
    int          err_beat;
    int          exp_we;
    int          exp_done;
    int          exp_err;
    int          exp_first;
    int          exp_len;
  } vec_t;
  vec_t vecs[6];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  task automatic do_fill(input logic [31:0] adr, input int waits, input int abort_beat, input int err_beat,
                         output int n_we, output int n_done, output int n_err, output int first, output int len);
    logic [31:0] base;
    int start, k, w, cnt;
    bit fin, abrt, a, e;
    base = {adr[31:4], 4'h0};
    start = int'(adr[3:1]);
    k = 0; w = 0; cnt = 0; fin = 0; abrt = 0;
    n_we = 0; n_done = 0; n_err = 0; first = -1;
    @(negedge clk);
    bus.miss_i = 1'b1; bus.miss_adr_i = adr;
    @(negedge clk);
    bus.miss_i = 1'b0; cnt = 1;
    while (!fin && cnt < 200) begin
      chk("cyc", {31'd0, bus.wb_cyc_o}, 32'd1);
      chk("adr", bus.wb_adr_o, base + 32'(2 * ((start + k) % 8)));
      a = (w == waits);
      e = a && (k == err_beat);
      bus.wb_ack_i = a; bus.wb_err_i = e;
      bus.abort_i = (k == abort_beat) && (w == 0);
      bus.wb_dat_i = 16'hC000 | 16'(k * 16 + start);
      #1;
      chk("fill_we", {31'd0, bus.fill_we_o}, {31'd0, a && !e && !abrt});
      if (bus.fill_we_o) begin
        n_we++;
        chk("fill_idx", 32'(bus.fill_idx_o), 32'((start + k) % 8));
        chk("crit", {31'd0, bus.crit_o}, {31'd0, k == 0});
        chk("fill_dat", 32'(bus.fill_dat_o), 32'(16'hC000 | 16'(k * 16 + start)));
        if (bus.crit_o) first = int'(bus.fill_idx_o);
      end
      n_done += int'(bus.done_o);
      n_err += int'(bus.err_o);
      fin = e || (a && (abrt || k == 7));
      if (bus.abort_i) abrt = 1;
      if (a) begin k++; w = 0; end else w++;
      @(negedge clk);
      bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.abort_i = 1'b0;
      cnt++;
    end
    if (!fin) chk("timeout", 32'd1, 32'd0);
    len = cnt;
    chk("cyc_end", {30'd0, bus.wb_cyc_o, bus.wb_stb_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      n_done += int'(bus.done_o);
      n_err += int'(bus.err_o);
      @(negedge clk);
    end
  endtask
  initial begin
    int n_we, n_done, n_err, first, len;
    bus.miss_i = 0; bus.miss_adr_i = 0; bus.abort_i = 0;
    bus.wb_dat_i = 0; bus.wb_ack_i = 0; bus.wb_err_i = 0;
    vecs[0] = '{32'h1000, 0, -1, -1, 8, 1, 0, 0, 9};
    vecs[1] = '{32'h100A, 0, -1, -1, 8, 1, 0, 5, 9};
    vecs[2] = '{32'h2006, 2, -1, -1, 8, 1, 0, 3, 25};
    vecs[3] = '{32'h1000, 2, 3, -1, 3, 0, 0, 0, 13};
    vecs[4] = '{32'h1000, 0, -1, 4, 4, 0, 1, 0, 6};
    vecs[5] = '{32'h300E, 1, -1, -1, 8, 1, 0, 7, 17};
    #12;
    chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    chk("rst_cyc", {30'd0, bus.wb_cyc_o, bus.wb_stb_o}, 32'd0);
    chk("rst_adr", bus.wb_adr_o, 32'd0);
    chk("rst_sel", {30'd0, bus.wb_sel_o}, 32'd3);
    chk("rst_pulses", {30'd0, bus.done_o, bus.err_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int v = 0; v < 6; v++) begin
      do_fill(vecs[v].adr, vecs[v].waits, vecs[v].abort_beat, vecs[v].err_beat, n_we, n_done, n_err, first, len);
      chk($sformatf("v%0d_we", v), 32'(n_we), 32'(vecs[v].exp_we));
      chk($sformatf("v%0d_done", v), 32'(n_done), 32'(vecs[v].exp_done));
      chk($sformatf("v%0d_err", v), 32'(n_err), 32'(vecs[v].exp_err));
      chk($sformatf("v%0d_first", v), 32'(first), 32'(vecs[v].exp_first));
      chk($sformatf("v%0d_len", v), 32'(len), 32'(vecs[v].exp_len));
    end
    @(negedge clk);
    bus.miss_i = 1'b1; bus.abort_i = 1'b1; bus.miss_adr_i = 32'h4000;
    @(negedge clk);
    bus.miss_i = 1'b0; bus.abort_i = 1'b0;
    #1 chk("miss_abort_idle", {31'd0, bus.busy_o}, 32'd0);
    @(negedge clk);
    bus.wb_ack_i = 1'b1;
    #1 chk("ack_idle_we", {31'd0, bus.fill_we_o}, 32'd0);
    @(negedge clk);
    bus.wb_ack_i = 1'b0;
    chk("ack_idle_state", {30'd0, bus.busy_o, bus.done_o}, 32'd0);
    @(negedge clk);
    bus.miss_i = 1'b1; bus.miss_adr_i = 32'h1004;
    @(negedge clk);
    bus.miss_i = 1'b0; bus.wb_ack_i = 1'b1;
    repeat (6) @(negedge clk);
    bus.wb_ack_i = 1'b0;
    #1 chk("rst_mid_adr", bus.wb_adr_o, 32'h1000);
    rst_n = 1'b0;
    #1 chk("rst_mid_async", {29'd0, bus.wb_cyc_o, bus.wb_stb_o, bus.busy_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_done += int'(bus.done_o) + int'(bus.err_o) + int'(bus.busy_o);
    end
    chk("rst_mid_quiet", 32'(n_done), 32'd0);
    do_fill(32'h1004, 0, -1, -1, n_we, n_done, n_err, first, len);
    chk("restart_we", 32'(n_we), 32'd8);
    chk("restart_done", 32'(n_done), 32'd1);
    chk("restart_first", 32'(first), 32'd2);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
